// File: rtl/tma_argmax_if.sv
// Sum-stream and result bundle for tma_argmax; margin exists only with TMA_ARGMAX_MARGIN_EN.
interface tma_argmax_if #(
  parameter int NUM_CLASS = 12,
  parameter int SUM_W     = 16
);
  localparam int IDX_W = $clog2(NUM_CLASS);

  logic                    sum_valid;
  logic signed [SUM_W-1:0] sum_data;
  logic                    tail_flush_en;
  logic                    argmax_done;
  logic [IDX_W-1:0]        pred_class;
  logic signed [SUM_W-1:0] pred_score;
  logic                    sum_error;
`ifdef TMA_ARGMAX_MARGIN_EN
  logic [SUM_W:0]          margin;

  modport master (
    output sum_valid, sum_data, tail_flush_en,
    input  argmax_done, pred_class, pred_score, sum_error, margin
  );
  modport slave (
    input  sum_valid, sum_data, tail_flush_en,
    output argmax_done, pred_class, pred_score, sum_error, margin
  );
`else
  modport master (
    output sum_valid, sum_data, tail_flush_en,
    input  argmax_done, pred_class, pred_score, sum_error
  );
  modport slave (
    input  sum_valid, sum_data, tail_flush_en,
    output argmax_done, pred_class, pred_score, sum_error
  );
`endif
endinterface

// File: rtl/tma_argmax.sv
// Streaming signed argmax over NUM_CLASS class sums with flush-triggered result.
// Optional TMA_ARGMAX_MARGIN_EN adds runner-up tracking and the best-minus-second margin.
module tma_argmax #(
  parameter int NUM_CLASS = 12,
  parameter int SUM_W     = 16
) (
  input  logic         clk,
  input  logic         rst,
  tma_argmax_if.slave  bus
);
  localparam int IDX_W = $clog2(NUM_CLASS);
  localparam int CNT_W = IDX_W + 1;

  typedef enum logic [1:0] {IDLE, COLLECT, READY} state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [SUM_W-1:0] best_val_q, best_val_d;
  logic [IDX_W-1:0]        best_idx_q, best_idx_d;
  logic [IDX_W-1:0]        pred_class_q, pred_class_d;
  logic signed [SUM_W-1:0] pred_score_q, pred_score_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  logic load_first, take_sum, flush, err_set, last_sum;

  assign last_sum = (cnt_q == CNT_W'(NUM_CLASS - 1));

`ifdef TMA_ARGMAX_MARGIN_EN
  localparam logic signed [SUM_W-1:0] SUM_MIN = {1'b1, {(SUM_W-1){1'b0}}};
  logic signed [SUM_W-1:0] second_q, second_d;
  logic [SUM_W:0]          margin_q, margin_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.sum_valid) state_d = (NUM_CLASS == 1) ? READY : COLLECT;
      COLLECT: if (bus.sum_valid && last_sum) state_d = READY;
      READY:   if (bus.tail_flush_en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A flush arriving with the final sum is not a missing-sum error.
  always_comb begin
    load_first = 1'b0;
    take_sum   = 1'b0;
    flush      = 1'b0;
    err_set    = 1'b0;
    case (state_q)
      IDLE: begin
        load_first = bus.sum_valid;
        err_set    = bus.tail_flush_en;
      end
      COLLECT: begin
        take_sum = bus.sum_valid;
        err_set  = bus.tail_flush_en && !(bus.sum_valid && last_sum);
      end
      READY: begin
        flush   = bus.tail_flush_en;
        err_set = bus.sum_valid;
      end
      default: ;
    endcase
  end

  always_comb begin
    cnt_d        = cnt_q;
    best_val_d   = best_val_q;
    best_idx_d   = best_idx_q;
    pred_class_d = pred_class_q;
    pred_score_d = pred_score_q;
    done_d       = flush;
    err_d        = flush ? 1'b0 : (err_q | err_set);
`ifdef TMA_ARGMAX_MARGIN_EN
    second_d     = second_q;
    margin_d     = margin_q;
`endif
    if (load_first) begin
      cnt_d      = CNT_W'(1);
      best_val_d = bus.sum_data;
      best_idx_d = '0;
`ifdef TMA_ARGMAX_MARGIN_EN
      second_d   = SUM_MIN;
`endif
    end else if (take_sum) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (bus.sum_data > best_val_q) begin
        best_val_d = bus.sum_data;
        best_idx_d = cnt_q[IDX_W-1:0];
`ifdef TMA_ARGMAX_MARGIN_EN
        second_d   = best_val_q;
      end else if (bus.sum_data > second_q) begin
        second_d   = bus.sum_data;
`endif
      end
    end
    if (flush) begin
      cnt_d        = '0;
      pred_class_d = best_idx_q;
      pred_score_d = best_val_q;
`ifdef TMA_ARGMAX_MARGIN_EN
      margin_d     = {best_val_q[SUM_W-1], best_val_q} - {second_q[SUM_W-1], second_q};
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      best_val_q   <= '0;
      best_idx_q   <= '0;
      pred_class_q <= '0;
      pred_score_q <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
`ifdef TMA_ARGMAX_MARGIN_EN
      second_q     <= '0;
      margin_q     <= '0;
`endif
    end else begin
      cnt_q        <= cnt_d;
      best_val_q   <= best_val_d;
      best_idx_q   <= best_idx_d;
      pred_class_q <= pred_class_d;
      pred_score_q <= pred_score_d;
      done_q       <= done_d;
      err_q        <= err_d;
`ifdef TMA_ARGMAX_MARGIN_EN
      second_q     <= second_d;
      margin_q     <= margin_d;
`endif
    end
  end

  assign bus.argmax_done = done_q;
  assign bus.pred_class  = pred_class_q;
  assign bus.pred_score  = pred_score_q;
  assign bus.sum_error   = err_q;
`ifdef TMA_ARGMAX_MARGIN_EN
  assign bus.margin      = margin_q;
`endif

endmodule

// File: tb/tb_tma_argmax.sv
// Scoreboard bench for tma_argmax: stimulus pushes model results, a monitor checks each done pulse.
module tb_tma_argmax;
  localparam int NC = 12;
  localparam int SW = 16;

  typedef struct {
    longint cls;
    longint score;
    longint mar;
    longint cyc;
  } exp_t;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  longint cyc = 0;
  int     total = 0;
  int     bad = 0;
  int     sv [NC];
  exp_t   exp_q [$];

  tma_argmax_if #(.NUM_CLASS(NC), .SUM_W(SW)) bus ();

  tma_argmax #(.NUM_CLASS(NC), .SUM_W(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: first maximum wins; runner-up is the largest of the remaining entries.
  function automatic exp_t model();
    exp_t e;
    int   bi = 0;
    int   sec = -(1 << (SW - 1));
    for (int k = 1; k < NC; k++)
      if (sv[k] > sv[bi]) bi = k;
    for (int k = 0; k < NC; k++)
      if (k != bi && sv[k] > sec) sec = sv[k];
    e.cls   = bi;
    e.score = sv[bi];
    e.mar   = sv[bi] - sec;
    e.cyc   = 0;
    return e;
  endfunction

  always @(negedge clk) begin
    if (bus.argmax_done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("done_cycle", cyc, e.cyc);
        check("pred_class", bus.pred_class, e.cls);
        check("pred_score", bus.pred_score, e.score);
        check("err_at_done", bus.sum_error, 0);
`ifdef TMA_ARGMAX_MARGIN_EN
        check("margin", bus.margin, e.mar);
`endif
      end
    end
  end

  task automatic feed(input int n);
    for (int k = 0; k < n; k++) begin
      bus.sum_valid = 1'b1;
      bus.sum_data  = SW'(sv[k]);
      step();
    end
    bus.sum_valid = 1'b0;
  endtask

  task automatic send_stream(input bit flush_same, input int unsigned gap_max,
                             input int unsigned delay, input bit surplus);
    exp_t e;
    e = model();
    for (int k = 0; k < NC; k++) begin
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) step();
      bus.sum_valid     = 1'b1;
      bus.sum_data      = SW'(sv[k]);
      bus.tail_flush_en = flush_same && (k == NC - 1);
      if (flush_same && k == NC - 1) begin
        e.cyc = cyc + 2;
        exp_q.push_back(e);
      end
      step();
      bus.sum_valid = 1'b0;
    end
    if (flush_same) begin
      check("err_flush_with_last", bus.sum_error, 0);
      step();
      bus.tail_flush_en = 1'b0;
    end else begin
      if (surplus) begin
        bus.sum_valid = 1'b1;
        bus.sum_data  = 16'sh7FFF;
        step();
        bus.sum_valid = 1'b0;
        check("err_surplus", bus.sum_error, 1);
      end
      repeat (delay) step();
      if (surplus) check("err_surplus_held", bus.sum_error, 1);
      bus.tail_flush_en = 1'b1;
      e.cyc = cyc + 1;
      exp_q.push_back(e);
      step();
      bus.tail_flush_en = 1'b0;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_done"},  bus.argmax_done, 0);
    check({tag, "_class"}, bus.pred_class, 0);
    check({tag, "_score"}, bus.pred_score, 0);
    check({tag, "_err"},   bus.sum_error, 0);
`ifdef TMA_ARGMAX_MARGIN_EN
    check({tag, "_margin"}, bus.margin, 0);
`endif
  endtask

  initial begin
    bus.sum_valid     = 1'b0;
    bus.sum_data      = '0;
    bus.tail_flush_en = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    check_zero("reset");

    sv = '{5, -3, 40, 7, 40, 0, 1, 2, 3, 4, 5, 6};
    send_stream(1'b0, 0, 0, 1'b0);
    step();

    foreach (sv[k]) sv[k] = -100;
    send_stream(1'b0, 0, 0, 1'b0);

    foreach (sv[k]) sv[k] = k;
    send_stream(1'b1, 0, 0, 1'b0);
    step();

    foreach (sv[k]) sv[k] = 10 - k;
    feed(6);
    bus.tail_flush_en = 1'b1;
    step();
    bus.tail_flush_en = 1'b0;
    check("err_missing_sums", bus.sum_error, 1);
    repeat (3) step();
    check("err_sticky", bus.sum_error, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_zero("midreset");

    foreach (sv[k]) sv[k] = k - 5;
    send_stream(1'b0, 0, 2, 1'b1);
    check("err_cleared_by_done", bus.sum_error, 0);

    foreach (sv[k]) sv[k] = -32768;
    sv[7] = 32767;
    send_stream(1'b0, 1, 1, 1'b0);
    sv[7] = -32768;
    sv[3] = 32767;
    sv[9] = 32767;
    send_stream(1'b1, 0, 0, 1'b0);

    // rst with a flush pending in READY must swallow the result
    foreach (sv[k]) sv[k] = 3 * k;
    feed(NC);
    rst = 1'b1;
    bus.sum_valid = 1'b1;
    bus.tail_flush_en = 1'b1;
    step();
    rst = 1'b0;
    bus.sum_valid = 1'b0;
    bus.tail_flush_en = 1'b0;
    check_zero("rst_priority");
    repeat (2) step();

    for (int it = 0; it < 30; it++) begin
      logic signed [SW-1:0] r;
      foreach (sv[k]) begin
        r = SW'($urandom);
        sv[k] = (it % 3 == 0) ? int'($urandom_range(0, 7)) - 4 : int'(r);
      end
      send_stream(1'($urandom_range(0, 1)), $urandom_range(0, 2),
                  $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      check("err_after_done", bus.sum_error, 0);
    end

    repeat (5) step();
    check("pending_results", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/tma_argmax.md
TMA_ARGMAX -- requirements
Module: tma_argmax

Interface
REQ-001 SHALL have parameter NUM_CLASS, default 12, number of keyword classes (legal range 2..64).
REQ-002 SHALL have parameter SUM_W, default 16, width of the signed two's-complement class sum.
REQ-003 SHALL derive localparam IDX_W = $clog2(NUM_CLASS), the width of the class index.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 Port clk, input, 1 bit: rising-edge clock.
REQ-006 Port rst, input, 1 bit: synchronous active-high reset.
REQ-007 Port sum_valid, input, 1 bit: sum_data is valid this cycle; the block accepts it with no backpressure.
REQ-008 Port sum_data, input, SUM_W bits, signed: class sum; the k-th accepted sum belongs to class k, counting from 0.
REQ-009 Port tail_flush_en, input, 1 bit: from the controller; inference is in its final phase and a result is requested.
REQ-010 Port argmax_done, output, 1 bit: one-cycle pulse; the result outputs are updated in the same cycle.
REQ-011 Port pred_class, output, IDX_W bits: index of the winning class.
REQ-012 Port pred_score, output, SUM_W bits, signed: the winning class sum.
REQ-013 Port sum_error, output, 1 bit: sticky flag for a stream protocol violation.
REQ-014 Port margin, output, SUM_W+1 bits, unsigned: best sum minus second-best sum; this port exists only when the macro in REQ-034 is defined.

Function
REQ-015 SHALL implement three states:
- IDLE: no sum received yet.
- COLLECT: 1..NUM_CLASS-1 sums received.
- READY: NUM_CLASS sums received.
REQ-016 SHALL keep an index counter cnt (IDX_W+1 bits); each accepted sum increments cnt by 1.
REQ-017 In IDLE, on sum_valid=1:
- load best_val = sum_data and best_idx = 0;
- set cnt = 1;
- go to COLLECT, or go directly to READY when NUM_CLASS = 1 (not a legal value per REQ-001).
REQ-018 In COLLECT, on sum_valid=1: replace best only when sum_data is strictly greater than best_val (signed compare), so a tie keeps the lower index.
REQ-019 In COLLECT, the transition to READY SHALL occur in the cycle the NUM_CLASS-th sum is accepted.
REQ-020 In READY with tail_flush_en=1:
- on the next edge, register pred_class = best_idx and pred_score = best_val;
- pulse argmax_done high for exactly one cycle;
- clear cnt and return to IDLE.
REQ-021 Latency: with the last sum at cycle t and tail_flush_en=1 from cycle t+1, argmax_done SHALL be high in cycle t+2 only.
REQ-022 In READY with tail_flush_en=0, SHALL hold the result and wait indefinitely.
REQ-023 sum_valid=1 while in READY (surplus sum) SHALL:
- set sum_error;
- discard the data;
- leave best and cnt unchanged.
REQ-024 tail_flush_en=1 in IDLE or COLLECT (sums missing) SHALL set sum_error and SHALL NOT assert argmax_done.
REQ-025 sum_error SHALL clear only on rst or on the cycle argmax_done pulses.
REQ-026 pred_class and pred_score SHALL hold their last values between results.
REQ-027 Comparisons SHALL be full SUM_W signed, with no truncation or saturation.
REQ-028 argmax_done SHALL never be asserted in two consecutive cycles.

Reset
REQ-029 With rst=1 at a clock edge, on that edge:
- state goes to IDLE and cnt to 0;
- argmax_done goes to 0 and sum_error to 0;
- pred_class, pred_score, best_idx and best_val go to 0;
- margin goes to 0.
REQ-030 Reset mid-stream (COLLECT or READY) SHALL discard partial results and produce no argmax_done pulse.
REQ-031 rst SHALL take priority over sum_valid and tail_flush_en in the same cycle.

Configuration
REQ-032 With macro TMA_ARGMAX_MARGIN_EN defined, the block SHALL also track second_val, the largest sum not selected as best.
REQ-033 With TMA_ARGMAX_MARGIN_EN defined, margin = best_val - second_val, registered together with pred_class.
REQ-034 With TMA_ARGMAX_MARGIN_EN defined, on a tie the second value equals the best value, so margin = 0.
REQ-035 With TMA_ARGMAX_MARGIN_EN undefined, the margin port, second_val and the associated logic SHALL be absent; all other behaviour is identical.

Verification
REQ-036 Sums 5,-3,40,7,40,0,1,2,3,4,5,6, then tail_flush_en=1 -> argmax_done at t+2, pred_class=2, pred_score=40, margin=0.
REQ-037 All 12 sums = -100 -> pred_class=0, pred_score=-100, margin=0.
REQ-038 Sums 0..11 ascending with tail_flush_en=1 in the same cycle as the last sum -> pred_class=11, pred_score=11, margin=1, done exactly one cycle after READY.
REQ-039 Six sums, then tail_flush_en=1 -> sum_error=1 and no argmax_done; next, rst=1 for one cycle -> all outputs 0.
REQ-040 Twelve sums, a 13th sum_valid in READY, then flush -> sum_error=1 until the done pulse, and pred_class is unaffected by the 13th value.
REQ-041 Sums with values 32767 and -32768 (SUM_W=16) -> the correct signed winner; margin=65535 under TMA_ARGMAX_MARGIN_EN.
